// File: rtl/pipe_stage_reg.sv
// Handshaked pipeline stage register carrying a ctrl and a data bundle, with synchronous flush.
// Latency: 1 cycle input to output; throughput 1 entry/cycle in either SKID mode.
// Backpressure: SKID=1 registers in_ready behind a 2-entry skid; SKID=0 passes out_ready combinationally to in_ready.
module pipe_stage_reg #(
    parameter int CTRL_W   = 16,
    parameter int DATA_W   = 128,
    parameter int SKID     = 1,
    parameter int CLR_DATA = 0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_flush,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [CTRL_W-1:0] i_in_ctrl,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CTRL_W-1:0] o_out_ctrl,
    output logic [DATA_W-1:0] o_out_data,
    output logic [1:0]        o_occupancy
);

    // Encoding equals the number of held entries, so occupancy is the state itself.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_live;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_emit;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != ST_EMPTY);

    // r_live keeps in_ready low for the first cycle after reset release.
    always_comb begin
        w_in_ready = 1'b0;
        if (SKID != 0) begin
            w_in_ready = r_live && i_reset && (r_state != ST_FULL);
        end else begin
            w_in_ready = r_live && i_reset && (!w_out_valid || i_out_ready);
        end
    end

    assign w_accept = i_in_valid && w_in_ready;
    assign w_emit   = w_out_valid && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state <= ST_EMPTY;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_live  <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_accept && w_emit) begin
                    w_load_main_in = 1'b1;
                end else if (w_accept) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_emit) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // The skid entry is older than anything upstream, so it always refills main first.
                if (w_emit) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (i_flush) begin
            r_main_ctrl <= '0;
            r_skid_ctrl <= '0;
            if (CLR_DATA != 0) begin
                r_main_data <= '0;
                r_skid_data <= '0;
            end
        end else begin
            if (w_load_main_in) begin
                r_main_ctrl <= i_in_ctrl;
                r_main_data <= i_in_data;
            end else if (w_load_main_skid) begin
                r_main_ctrl <= r_skid_ctrl;
                r_main_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_ctrl <= i_in_ctrl;
                r_skid_data <= i_in_data;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_out_ctrl  = w_out_valid ? r_main_ctrl : '0;
    assign o_out_data  = r_main_data;
    assign o_occupancy = 2'(r_state);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance, vector table, corner sequences, random vs queue model.
module tb_pipe_stage_reg;

    localparam int CW = 16;
    localparam int DW = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush;
    logic          a_iv, a_ir, a_ov, a_or;
    logic [CW-1:0] a_ic, a_oc;
    logic [DW-1:0] a_id, a_od;
    logic [1:0]    a_occ;
    logic          b_iv, b_ir, b_ov, b_or;
    logic [CW-1:0] b_ic, b_oc;
    logic [DW-1:0] b_id, b_od;
    logic [1:0]    b_occ;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0)) u_dut_a (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush),
        .i_in_valid(a_iv), .o_in_ready(a_ir), .i_in_ctrl(a_ic), .i_in_data(a_id),
        .o_out_valid(a_ov), .i_out_ready(a_or), .o_out_ctrl(a_oc), .o_out_data(a_od),
        .o_occupancy(a_occ)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0)) u_dut_b (
        .i_clk(clk), .i_reset(rst_n), .i_flush(flush),
        .i_in_valid(b_iv), .o_in_ready(b_ir), .i_in_ctrl(b_ic), .i_in_data(b_id),
        .o_out_valid(b_ov), .i_out_ready(b_or), .o_out_ctrl(b_oc), .o_out_data(b_od),
        .o_occupancy(b_occ)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] dat_of(input logic [15:0] c);
        return 64'hDA7A_0000_0000_0000 | {48'h0, c};
    endfunction

    typedef struct {
        logic        iv;
        logic [15:0] ic;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [15:0] ec;
        logic [1:0]  eocc;
        logic        erdy;
        logic [15:0] dkey;
    } vec_t;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    vec_t tbl [17];
    ent_t qa[$];
    ent_t qb[$];

    initial begin
        bit live;
        bit acc_a, emi_a, acc_b, emi_b, m_rdy_a, m_rdy_b;
        ent_t e;

        // columns: in_valid, in_ctrl, out_ready, flush | out_valid, out_ctrl, occupancy, in_ready, data key
        tbl[0]  = '{1'b1, 16'd1,  1'b1, 1'b0, 1'b1, 16'd1,  2'd1, 1'b1, 16'd1};
        tbl[1]  = '{1'b1, 16'd2,  1'b1, 1'b0, 1'b1, 16'd2,  2'd1, 1'b1, 16'd2};
        tbl[2]  = '{1'b1, 16'd3,  1'b1, 1'b0, 1'b1, 16'd3,  2'd1, 1'b1, 16'd3};
        tbl[3]  = '{1'b1, 16'd4,  1'b1, 1'b0, 1'b1, 16'd4,  2'd1, 1'b1, 16'd4};
        tbl[4]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  2'd0, 1'b1, 16'd0};
        tbl[5]  = '{1'b1, 16'd5,  1'b0, 1'b0, 1'b1, 16'd5,  2'd1, 1'b1, 16'd5};
        tbl[6]  = '{1'b1, 16'd6,  1'b0, 1'b0, 1'b1, 16'd5,  2'd2, 1'b0, 16'd5};
        tbl[7]  = '{1'b1, 16'd99, 1'b0, 1'b0, 1'b1, 16'd5,  2'd2, 1'b0, 16'd5};
        tbl[8]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b1, 16'd6,  2'd1, 1'b1, 16'd6};
        tbl[9]  = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  2'd0, 1'b1, 16'd0};
        tbl[10] = '{1'b1, 16'd7,  1'b0, 1'b0, 1'b1, 16'd7,  2'd1, 1'b1, 16'd7};
        tbl[11] = '{1'b1, 16'd8,  1'b0, 1'b0, 1'b1, 16'd7,  2'd2, 1'b0, 16'd7};
        tbl[12] = '{1'b1, 16'd9,  1'b0, 1'b1, 1'b0, 16'd0,  2'd0, 1'b1, 16'd7};
        tbl[13] = '{1'b1, 16'd10, 1'b0, 1'b0, 1'b1, 16'd10, 2'd1, 1'b1, 16'd10};
        tbl[14] = '{1'b1, 16'd11, 1'b0, 1'b1, 1'b0, 16'd0,  2'd0, 1'b1, 16'd10};
        tbl[15] = '{1'b0, 16'd0,  1'b1, 1'b0, 1'b0, 16'd0,  2'd0, 1'b1, 16'd0};
        tbl[16] = '{1'b1, 16'd12, 1'b1, 1'b0, 1'b1, 16'd12, 2'd1, 1'b1, 16'd12};

        // Reset held with a live input on both instances.
        rst_n = 1'b0; flush = 1'b0;
        a_iv = 1'b1; a_ic = 16'hFFFF; a_id = '1; a_or = 1'b0;
        b_iv = 1'b1; b_ic = 16'hFFFF; b_id = '1; b_or = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.a_valid", a_ov, 0);  chk("rst.a_ctrl", a_oc, 0);
        chk("rst.a_occ", a_occ, 0);   chk("rst.a_ready", a_ir, 0);
        chk("rst.a_data", a_od, 0);
        chk("rst.b_valid", b_ov, 0);  chk("rst.b_ctrl", b_oc, 0);
        chk("rst.b_occ", b_occ, 0);   chk("rst.b_ready", b_ir, 0);
        @(negedge clk);
        rst_n = 1'b1; a_iv = 1'b0; b_iv = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.a_ready_after", a_ir, 1);
        chk("rst.b_ready_after", b_ir, 1);
        chk("rst.a_valid_after", a_ov, 0);

        // Streaming, backpressure and flush on the skid instance.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            a_iv = tbl[i].iv; a_ic = tbl[i].ic; a_id = dat_of(tbl[i].ic);
            a_or = tbl[i].ordy; flush = tbl[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.valid", i), a_ov, tbl[i].ev);
            chk($sformatf("vec%0d.ctrl", i), a_oc, tbl[i].ec);
            chk($sformatf("vec%0d.occ", i), a_occ, tbl[i].eocc);
            chk($sformatf("vec%0d.in_ready", i), a_ir, tbl[i].erdy);
            if (tbl[i].dkey != 0) chk($sformatf("vec%0d.data", i), a_od, dat_of(tbl[i].dkey));
        end
        @(negedge clk);
        flush = 1'b0;

        // Single-entry stall: in_ready follows out_ready in the same cycle.
        b_iv = 1'b1; b_ic = 16'h21; b_id = dat_of(16'h21); b_or = 1'b0;
        @(posedge clk);
        #1;
        chk("s0.valid", b_ov, 1); chk("s0.ctrl", b_oc, 16'h21);
        chk("s0.occ", b_occ, 1);  chk("s0.stall_ready", b_ir, 0);
        @(negedge clk);
        b_ic = 16'h22; b_id = dat_of(16'h22); b_or = 1'b1;
        #1;
        chk("s0.ready_same_cycle", b_ir, 1);
        @(posedge clk);
        #1;
        chk("s0.replace_ctrl", b_oc, 16'h22);
        chk("s0.replace_data", b_od, dat_of(16'h22));
        chk("s0.replace_occ", b_occ, 1);
        @(negedge clk);
        b_iv = 1'b0; b_or = 1'b0;
        #1;
        chk("s0.stall_ready2", b_ir, 0);
        @(negedge clk);
        b_or = 1'b1;
        @(posedge clk);
        #1;
        chk("s0.drain_valid", b_ov, 0);
        chk("s0.drain_occ", b_occ, 0);

        // Reset in the middle of a burst with the skid full.
        @(negedge clk);
        b_or = 1'b0;
        a_iv = 1'b1; a_ic = 16'h31; a_id = dat_of(16'h31); a_or = 1'b0;
        @(negedge clk);
        a_ic = 16'h32; a_id = dat_of(16'h32);
        #1;
        chk("mid.occ_full", a_occ, 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid.valid", a_ov, 0); chk("mid.occ", a_occ, 0);
        chk("mid.ctrl", a_oc, 0);  chk("mid.ready", a_ir, 0);
        chk("mid.data", a_od, 0);
        @(negedge clk);
        rst_n = 1'b1; a_ic = 16'h33; a_id = dat_of(16'h33); a_or = 1'b1;
        @(posedge clk);
        #1;
        chk("mid.ready_after", a_ir, 1);
        chk("mid.valid_after", a_ov, 0);
        @(posedge clk);
        #1;
        chk("mid.first_valid", a_ov, 1);
        chk("mid.first_ctrl", a_oc, 16'h33);

        // Random traffic against queue models of both instances.
        @(negedge clk);
        rst_n = 1'b0; a_iv = 1'b0; b_iv = 1'b0;
        @(posedge clk);
        live = 1'b0;
        qa.delete(); qb.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = ($urandom_range(0, 199) != 0);
            flush = ($urandom_range(0, 29) == 0);
            a_iv = ($urandom_range(0, 3) != 0); a_ic = CW'($urandom); a_id = {$urandom, $urandom};
            a_or = ($urandom_range(0, 3) != 0);
            b_iv = ($urandom_range(0, 3) != 0); b_ic = CW'($urandom); b_id = {$urandom, $urandom};
            b_or = ($urandom_range(0, 2) != 0);
            #1;
            m_rdy_a = live && rst_n && (qa.size() < 2);
            m_rdy_b = live && rst_n && (qb.size() == 0 || b_or);
            chk("rnd.a_ready", a_ir, m_rdy_a);
            chk("rnd.a_valid", a_ov, qa.size() > 0);
            chk("rnd.a_occ", a_occ, qa.size());
            chk("rnd.a_ctrl", a_oc, (qa.size() > 0) ? qa[0].c : '0);
            if (qa.size() > 0) chk("rnd.a_data", a_od, qa[0].d);
            chk("rnd.b_ready", b_ir, m_rdy_b);
            chk("rnd.b_valid", b_ov, qb.size() > 0);
            chk("rnd.b_occ", b_occ, qb.size());
            chk("rnd.b_ctrl", b_oc, (qb.size() > 0) ? qb[0].c : '0);
            if (qb.size() > 0) chk("rnd.b_data", b_od, qb[0].d);
            acc_a = a_iv && m_rdy_a; emi_a = (qa.size() > 0) && a_or;
            acc_b = b_iv && m_rdy_b; emi_b = (qb.size() > 0) && b_or;
            @(posedge clk);
            if (!rst_n) begin
                live = 1'b0; qa.delete(); qb.delete();
            end else begin
                live = 1'b1;
                if (flush) begin
                    qa.delete(); qb.delete();
                end else begin
                    if (emi_a) void'(qa.pop_front());
                    if (acc_a) begin e.c = a_ic; e.d = a_id; qa.push_back(e); end
                    if (emi_b) void'(qb.pop_front());
                    if (acc_b) begin e.c = b_ic; e.d = b_id; qb.push_back(e); end
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
